// File: rtl/nand_share_arbiter.sv
// nand_share_arbiter: four requesters share one multi-cycle NAND unit.
// The default build uses round-robin arbitration. Defining
// NAND_ARB_FIXED_PRIORITY_EN selects fixed priority instead (req[0] highest,
// no rotating pointer).
module nand_share_arbiter #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           req,
    input  logic [4*WIDTH-1:0]   a_in,
    input  logic [4*WIDTH-1:0]   b_in,
    output logic [3:0]           grant,
    output logic                 valid,
    output logic [WIDTH-1:0]     y_out,
    output logic                 busy
);

    localparam int unsigned NREQ  = 4;
    localparam int unsigned IDX_W = 2;
    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [NREQ-1:0]    grant_q, grant_d;
    logic               valid_q, valid_d;
    logic [WIDTH-1:0]   y_q, y_d;
    logic               busy_q, busy_d;
`ifndef NAND_ARB_FIXED_PRIORITY_EN
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [IDX_W-1:0]   win_q, win_d;
`endif

    logic               win_found_c;
    logic [IDX_W-1:0]   win_idx_c;
    logic [WIDTH-1:0]   a_sel_c;
    logic [WIDTH-1:0]   b_sel_c;

    // Winner search; descending scan so the lowest-ranked candidate is written last.
    always_comb begin
        win_found_c = 1'b0;
        win_idx_c   = '0;
`ifdef NAND_ARB_FIXED_PRIORITY_EN
        for (int i = 3; i >= 0; i--) begin
            if (req[i]) begin
                win_found_c = 1'b1;
                win_idx_c   = IDX_W'(i);
            end
        end
`else
        for (int i = 3; i >= 0; i--) begin
            if (req[IDX_W'(ptr_q + IDX_W'(i))]) begin
                win_found_c = 1'b1;
                win_idx_c   = IDX_W'(ptr_q + IDX_W'(i));
            end
        end
`endif
    end

    // Operand slice of the current winner.
    always_comb begin
        a_sel_c = '0;
        b_sel_c = '0;
        for (int i = 0; i < 4; i++) begin
            if (win_idx_c == IDX_W'(i)) begin
                a_sel_c = a_in[i*WIDTH +: WIDTH];
                b_sel_c = b_in[i*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        grant_d = grant_q;
        valid_d = 1'b0;
        y_d     = y_q;
`ifndef NAND_ARB_FIXED_PRIORITY_EN
        ptr_d   = ptr_q;
        win_d   = win_q;
`endif
        case (state_q)
            S_IDLE: begin
                grant_d = '0;
                if (win_found_c) begin
                    state_d = S_EXEC;
                    a_d     = a_sel_c;
                    b_d     = b_sel_c;
                    grant_d = NREQ'(1) << win_idx_c;
                    cnt_d   = CNT_W'(LATENCY - 1);
`ifndef NAND_ARB_FIXED_PRIORITY_EN
                    win_d   = win_idx_c;
`endif
                end
            end
            S_EXEC: begin
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                    valid_d = 1'b1;
                    y_d     = ~(a_q & b_q);
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                grant_d = '0;
`ifndef NAND_ARB_FIXED_PRIORITY_EN
                ptr_d   = win_q + IDX_W'(1);
`endif
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            grant_q <= '0;
            valid_q <= 1'b0;
            y_q     <= '0;
            busy_q  <= 1'b0;
`ifndef NAND_ARB_FIXED_PRIORITY_EN
            ptr_q   <= '0;
            win_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            grant_q <= grant_d;
            valid_q <= valid_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
`ifndef NAND_ARB_FIXED_PRIORITY_EN
            ptr_q   <= ptr_d;
            win_q   <= win_d;
`endif
        end
    end

    assign grant = grant_q;
    assign valid = valid_q;
    assign y_out = y_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_nand_share_arbiter.sv
// Self-checking bench for nand_share_arbiter (WIDTH=16, LATENCY=2).
module tb_nand_share_arbiter;

    localparam int unsigned WIDTH   = 16;
    localparam int unsigned LATENCY = 2;

    logic               clk;
    logic               reset;
    logic [3:0]         req;
    logic [4*WIDTH-1:0] a_in;
    logic [4*WIDTH-1:0] b_in;
    logic [3:0]         grant;
    logic               valid;
    logic [WIDTH-1:0]   y_out;
    logic               busy;

    nand_share_arbiter #(.WIDTH(WIDTH), .LATENCY(LATENCY)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .a_in  (a_in),
        .b_in  (b_in),
        .grant (grant),
        .valid (valid),
        .y_out (y_out),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Transaction-level reference: an operation occupies LATENCY+2 edges in total.
    int          m_left;
    int          m_win;
    int          m_p;
    logic [15:0] m_y;
    logic [15:0] m_pend;
    logic [3:0]  m_grant;
    logic        m_valid;

    function automatic int pick(input int p, input logic [3:0] rq);
`ifdef NAND_ARB_FIXED_PRIORITY_EN
        for (int k = 0; k < 4; k++) if (rq[k]) return k;
`else
        for (int k = 0; k < 4; k++) if (rq[(p + k) % 4]) return (p + k) % 4;
`endif
        return -1;
    endfunction

    task automatic model_update(input logic r, input logic [3:0] rq,
                                input logic [63:0] a, input logic [63:0] b);
        if (r) begin
            m_left = 0; m_p = 0; m_y = '0; m_valid = 1'b0; m_grant = '0;
        end else if (m_left == 0) begin
            m_valid = 1'b0;
            if (rq != 4'b0) begin
                m_win   = pick(m_p, rq);
                m_left  = LATENCY + 1;
                m_grant = 4'(1 << m_win);
                m_pend  = ~(a[m_win*16 +: 16] & b[m_win*16 +: 16]);
            end
        end else begin
            m_left--;
            if (m_left == 0) begin
                m_grant = '0; m_valid = 1'b0; m_p = (m_win + 1) % 4;
            end else if (m_left == 1) begin
                m_valid = 1'b1; m_y = m_pend;
            end else begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic step(input logic r, input logic [3:0] rq,
                        input logic [63:0] a, input logic [63:0] b);
        reset = r; req = rq; a_in = a; b_in = b;
        @(posedge clk);
        #1;
        model_update(r, rq, a, b);
    endtask

    typedef struct {
        logic        rst;
        logic [3:0]  rq;
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  g;
        logic        v;
        logic [15:0] y;
        logic        bz;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic rst, input logic [3:0] rq, input logic [63:0] a,
                       input logic [63:0] b, input logic [3:0] g, input logic v,
                       input logic [15:0] y, input logic bz);
        vec_t e;
        e.rst = rst; e.rq = rq; e.a = a; e.b = b; e.g = g; e.v = v; e.y = y; e.bz = bz;
        tbl.push_back(e);
    endtask

    initial begin
        logic [63:0] a1, b1, a2, b2, a3, b3;
        logic [3:0]  g1;
        logic [15:0] y1;
        logic [3:0]  exp_rot [5];
        int          seen;
        int          last;

        reset = 1'b1; req = '0; a_in = '0; b_in = '0;
        m_left = 0; m_win = 0; m_p = 0; m_y = '0; m_pend = '0; m_grant = '0; m_valid = 1'b0;

        a1 = {48'h0, 16'hFFFF};  b1 = {48'h0, 16'h0F0F};
        a2 = {48'h0, 16'h00FF};  b2 = {48'h0, 16'hFFFF};
        a3 = {16'hFFFF, 16'h0, 16'h5555, 16'h0};
        b3 = {16'h1234, 16'h0, 16'hAAAA, 16'h0};
`ifdef NAND_ARB_FIXED_PRIORITY_EN
        g1 = 4'b0010; y1 = 16'hFFFF;
        exp_rot = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
        g1 = 4'b1000; y1 = 16'hEDCB;
        exp_rot = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif

        // Directed vectors: single request, operand isolation, pointer respect.
        add(1, 4'b0000, 0,  0,  4'b0000, 0, 16'h0000, 0);
        add(0, 4'b0001, a1, b1, 4'b0001, 0, 16'h0000, 1);
        add(0, 4'b0000, 0,  0,  4'b0001, 0, 16'h0000, 1);
        add(0, 4'b0000, 0,  0,  4'b0001, 1, 16'hF0F0, 1);
        add(0, 4'b0000, 0,  0,  4'b0000, 0, 16'hF0F0, 0);
        add(0, 4'b0001, a2, b2, 4'b0001, 0, 16'hF0F0, 1);
        add(0, 4'b0000, 0,  0,  4'b0001, 0, 16'hF0F0, 1);
        add(0, 4'b0000, 0,  0,  4'b0001, 1, 16'hFF00, 1);
        add(0, 4'b0000, 0,  0,  4'b0000, 0, 16'hFF00, 0);
        add(0, 4'b0010, a3, b3, 4'b0010, 0, 16'hFF00, 1);
        add(0, 4'b0010, a3, b3, 4'b0010, 0, 16'hFF00, 1);
        add(0, 4'b1010, a3, b3, 4'b0010, 1, 16'hFFFF, 1);
        add(0, 4'b1010, a3, b3, 4'b0000, 0, 16'hFFFF, 0);
        add(0, 4'b1010, a3, b3, g1,      0, 16'hFFFF, 1);
        add(0, 4'b1010, a3, b3, g1,      0, 16'hFFFF, 1);
        add(0, 4'b1010, a3, b3, g1,      1, y1,       1);
        add(0, 4'b1010, a3, b3, 4'b0000, 0, y1,       0);
        add(0, 4'b1010, a3, b3, 4'b0010, 0, y1,       1);
        add(0, 4'b0000, a3, b3, 4'b0010, 0, y1,       1);
        add(0, 4'b0000, a3, b3, 4'b0010, 1, 16'hFFFF, 1);
        add(0, 4'b0000, a3, b3, 4'b0000, 0, 16'hFFFF, 0);

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].rq, tbl[i].a, tbl[i].b);
            chk($sformatf("vec%0d_grant", i), 64'(grant), 64'(tbl[i].g));
            chk($sformatf("vec%0d_valid", i), 64'(valid), 64'(tbl[i].v));
            chk($sformatf("vec%0d_y", i),     64'(y_out), 64'(tbl[i].y));
            chk($sformatf("vec%0d_busy", i),  64'(busy),  64'(tbl[i].bz));
        end

        // All requesters held: grant order and strobe spacing.
        step(1, 4'b0000, 0, 0);
        seen = 0; last = -1;
        for (int c = 0; c < 40 && seen < 5; c++) begin
            step(0, 4'b1111, {$urandom, $urandom}, {$urandom, $urandom});
            if (valid) begin
                chk($sformatf("rot%0d_grant", seen), 64'(grant), 64'(exp_rot[seen]));
                if (last >= 0) chk("rot_spacing", 64'(c - last), 64'(LATENCY + 2));
                last = c;
                seen++;
            end
        end
        chk("rot_count", 64'(seen), 64'd5);

        // Reset during the second EXEC cycle aborts the operation.
        for (int c = 0; c < 8 && busy; c++) step(0, 4'b0000, 0, 0);
        chk("abort_pre_idle", 64'(busy), 64'd0);
        step(0, 4'b0100, {16'h0, 16'h1111, 32'h0}, {16'h0, 16'h2222, 32'h0});
        chk("abort_grant", 64'(grant), 64'h4);
        step(0, 4'b0000, 0, 0);
        chk("abort_exec2_busy", 64'(busy), 64'd1);
        step(1, 4'b1111, 0, 0);
        chk("abort_rst_grant", 64'(grant), 64'd0);
        chk("abort_rst_valid", 64'(valid), 64'd0);
        chk("abort_rst_busy",  64'(busy),  64'd0);
        chk("abort_rst_y",     64'(y_out), 64'd0);
        for (int c = 0; c < 5; c++) begin
            step(0, 4'b0000, 0, 0);
            chk($sformatf("abort_novalid%0d", c), 64'(valid), 64'd0);
        end

`ifdef NAND_ARB_FIXED_PRIORITY_EN
        // Requester 1 always beats requester 3.
        step(1, 4'b0000, 0, 0);
        for (int c = 0; c < 16; c++) begin
            step(0, 4'b1010, 0, 0);
            if (grant != 4'b0000) chk($sformatf("fp_grant%0d", c), 64'(grant), 64'h2);
        end
`endif

        // Randomized traffic against the reference model.
        step(1, 4'b0000, 0, 0);
        for (int c = 0; c < 1500; c++) begin
            logic        r;
            logic [3:0]  rq;
            r  = ($urandom_range(0, 60) == 0);
            rq = 4'($urandom);
            step(r, rq, {$urandom, $urandom}, {$urandom, $urandom});
            chk($sformatf("rand%0d_grant", c), 64'(grant), 64'(m_grant));
            chk($sformatf("rand%0d_valid", c), 64'(valid), 64'(m_valid));
            chk($sformatf("rand%0d_y", c),     64'(y_out), 64'(m_y));
            chk($sformatf("rand%0d_busy", c),  64'(busy),  64'(m_left != 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/nand_share_arbiter.md
NAND_SHARE_ARBITER -- requirements
Module: nand_share_arbiter

Interface
REQ-001 Parameter WIDTH, default 16: operand and result width in bits.
REQ-002 Parameter LATENCY, default 2: execute cycles of the shared NAND unit; legal range 1..15.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 req  input  4  per-requester request; bit i belongs to requester i.
REQ-006 a_in  input  4*WIDTH  operand A; requester i uses slice [i*WIDTH +: WIDTH].
REQ-007 b_in  input  4*WIDTH  operand B; same slicing as a_in.
REQ-008 grant  output  4  registered one-hot grant; all zero when idle.
REQ-009 valid  output  1  one-cycle result strobe.
REQ-010 y_out  output  WIDTH  registered result, ~(A & B) of the granted requester.
REQ-011 busy  output  1  high whenever the state is not IDLE.

Function
REQ-012 FSM states SHALL be IDLE, EXEC and DONE, with transitions IDLE->EXEC (any req high), EXEC->DONE (counter = 0) and DONE->IDLE (unconditional).
REQ-013 IDLE SHALL pick a winner only when req != 0: it latches that requester's A and B, sets grant to its one-hot code and loads the counter with LATENCY-1.
REQ-014 Arbitration SHALL be round-robin: the search starts at pointer p and ascends mod 4, and the first set req bit wins.
REQ-015 Pointer p SHALL update only on the DONE cycle, to (winner+1) mod 4.
REQ-016 EXEC SHALL last exactly LATENCY cycles, with the counter decrementing once per cycle.
REQ-017 The DONE cycle SHALL assert valid=1, present y_out = ~(A_latched & B_latched) and keep grant held.
REQ-018 Timing: req sampled at edge k gives grant from edge k+1 and valid high for the one cycle following edge k+1+LATENCY.
REQ-019 The DONE->IDLE transition SHALL clear grant and valid; y_out SHALL hold its last value.
REQ-020 Minimum spacing SHALL be LATENCY+2 cycles per operation; there SHALL be no back-to-back grant without an IDLE cycle.
REQ-021 Changes on req, a_in or b_in during EXEC or DONE SHALL NOT affect the in-flight result.
REQ-022 If the granted req drops during EXEC, the operation SHALL still complete and valid SHALL still pulse.
REQ-023 A requester holding req high after its valid pulse SHALL be re-arbitrated normally in the next IDLE cycle.
REQ-024 valid SHALL never be high while grant is zero.
REQ-025 grant SHALL never have more than one bit set.

Reset
REQ-026 With reset high at an edge, the block SHALL go to IDLE, set grant=0, valid=0, y_out=0, busy=0, pointer p=0 and counter=0.
REQ-027 Reset SHALL override every state, including mid-EXEC and DONE.
REQ-028 An aborted operation SHALL produce no valid pulse.
REQ-029 req sampled in the same cycle as reset SHALL be ignored.

Configuration
REQ-030 Macro NAND_ARB_FIXED_PRIORITY_EN selects the arbitration scheme.
REQ-031 With NAND_ARB_FIXED_PRIORITY_EN defined, arbitration SHALL be fixed priority (req[0] highest, req[3] lowest), pointer p SHALL be removed, and starvation is permitted.
REQ-032 With NAND_ARB_FIXED_PRIORITY_EN undefined, arbitration SHALL be round-robin per REQ-014 and REQ-015.
REQ-033 All other behaviour SHALL be identical with and without the macro.

Verification (WIDTH=16, LATENCY=2)
REQ-034 Single request: reset, then req=0001, A0=16'hFFFF, B0=16'h0F0F sampled at edge k -> grant=0001 from k+1, valid=1 with y_out=16'hF0F0 after edge k+3, grant=0000 after k+4.
REQ-035 Round-robin rotation: req=1111 held continuously -> grant sequence 0001, 0010, 0100, 1000, 0001, with valid pulses exactly 4 cycles apart.
REQ-036 Pointer respect: after requester 1 completes (p=2), req=1010 -> grant=1000 first, then 0010.
REQ-037 Reset mid-operation: reset during the second EXEC cycle -> next cycle grant=0000, valid=0, busy=0, y_out=0; no valid pulse follows.
REQ-038 Operand isolation: req0 granted with A=16'h00FF, B=16'hFFFF, then A, B changed to 0 and req dropped during EXEC -> valid still pulses with y_out=16'hFF00.
REQ-039 Fixed priority, macro defined: req=1010 held -> grant=0010 on every operation and requester 3 is never granted.
